if_fetch_queue: RTL and testbench

- Parametrised successor to the single-register IF stage.
- Fetches instructions from an external synchronous-read instruction memory into a DEPTH-entry prefetch queue of {PC, instruction} pairs.
- Presents the queue head to ID.
- Handles Branch/Jump redirects with queue flush, and IFWrite stalls without losing fetched words.

---
 rtl/if_fetch_queue.sv | 133 +++++++++++++
 tb/tb_if_fetch_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a DEPTH-entry prefetch queue.
// Issues fetches to a synchronous-read instruction memory (1-cycle latency),
// queues {PC, instruction} pairs, presents the head to ID, and handles
// Branch/Jump redirects (queue flush, in-flight response dropped) and
// IFWrite stalls. Optional performance counters: define IF_PERF_EN.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INSN = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Branch,
  input  logic [XLEN-1:0]          BranchAddr,
  input  logic                     Jump,
  input  logic [XLEN-1:0]          JumpAddr,
  input  logic                     IFWrite,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic [XLEN-1:0]          Instruction_if,
  output logic [XLEN-1:0]          PC,
  output logic                     if_valid,
  output logic                     IF_flush,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [31:0]              perf_redirects,
  output logic [31:0]              perf_stalls
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] insn_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] fetch_pc;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   occ;
  logic            issue;
  logic            enq;
  logic            deq;
  logic            head_valid;

  // Redirect selection, issue/enqueue/dequeue decisions.
  // Issue uses pre-dequeue occupancy including the in-flight fetch, so a
  // returning word always has a free slot.
  always_comb begin
    redirect   = Branch | Jump;
    target     = Branch ? BranchAddr : JumpAddr;
    target[1:0] = 2'b00;
    occ        = count + CW'(inflight);
    head_valid = (count != '0);
    issue      = reset & ~redirect & (occ < CW'(DEPTH));
    enq        = inflight & ~redirect;
    deq        = head_valid & IFWrite & ~redirect;
  end

  // Control state: pointers, occupancy, in-flight tracking and fetch PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= RESET_PC;
    end else if (redirect) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      fetch_pc <= target;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Queue storage; needs no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]   <= inflight_pc;
      insn_mem[tail] <= imem_rdata;
    end
  end

  // Head presentation and memory request outputs.
  always_comb begin
    if_valid       = head_valid;
    Instruction_if = head_valid ? insn_mem[head] : NOP_INSN;
    PC             = head_valid ? pc_mem[head] : '0;
    imem_req       = issue;
    imem_addr      = fetch_pc;
    IF_flush       = redirect;
    q_count        = count;
  end

`ifdef IF_PERF_EN
  logic [31:0] redir_cnt;
  logic [31:0] stall_cnt;

  // Saturating redirect and stall-cycle counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (redirect && (redir_cnt != '1)) redir_cnt <= redir_cnt + 32'd1;
      if (head_valid && !IFWrite && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_redirects = redir_cnt;
  assign perf_stalls    = stall_cnt;
`else
  assign perf_redirects = '0;
  assign perf_stalls    = '0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue with a scoreboard of expected head PCs.
module tb_if_fetch_queue;

  logic        clk;
  logic        reset;
  logic        Branch;
  logic [31:0] BranchAddr;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        IFWrite;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_if;
  logic [31:0] PC;
  logic        if_valid;
  logic        IF_flush;
  logic [2:0]  q_count;
  logic [31:0] perf_redirects;
  logic [31:0] perf_stalls;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef IF_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_fetch_queue #(
    .XLEN(32),
    .DEPTH(4),
    .RESET_PC(32'h0),
    .NOP_INSN(32'h00000013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Branch(Branch),
    .BranchAddr(BranchAddr),
    .Jump(Jump),
    .JumpAddr(JumpAddr),
    .IFWrite(IFWrite),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .Instruction_if(Instruction_if),
    .PC(PC),
    .if_valid(if_valid),
    .IF_flush(IF_flush),
    .q_count(q_count),
    .perf_redirects(perf_redirects),
    .perf_stalls(perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0001;
  endfunction

  // Synchronous-read instruction memory; garbage when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? insn_of(imem_addr) : 32'hDEAD_BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // A head that will be consumed at the coming edge must match the scoreboard.
  task automatic consume_check();
    logic [31:0] e;
    if (if_valid === 1'b1 && IFWrite === 1'b1 && IF_flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_valid observed=%h expected=none", PC);
        end
      end else begin
        e = exp_q.pop_front();
        chk("head_pc", PC, e);
        chk("head_insn", Instruction_if, insn_of(e));
      end
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic adv();
    consume_check();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  initial begin
    reset = 1'b0; Branch = 1'b0; BranchAddr = '0; Jump = 1'b0; JumpAddr = '0; IFWrite = 1'b1;
    @(posedge clk); #1;

    // Reset held two cycles
    step();
    settle();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_insn", Instruction_if, 32'h00000013);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_perf_r", perf_redirects, 32'd0);
    chk("rst_perf_s", perf_stalls, 32'd0);
    adv();

    // Release: fetch from RESET_PC, head valid two cycles later
    reset = 1'b1;
    push_seq(32'h0, 64);
    settle();
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", 32'(if_valid), 32'd0);
    adv();
    settle();
    chk("c1_valid", 32'(if_valid), 32'd0);
    chk("c1_addr", imem_addr, 32'h4);
    adv();
    settle();
    chk("c2_valid", 32'(if_valid), 32'd1);
    chk("c2_pc", PC, 32'h0);
    adv();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stream_valid", 32'(if_valid), 32'd1);
      adv();
    end
    settle();
    chk("steady_count", 32'(q_count), 32'd1);

    // Stall for 8 cycles
    IFWrite = 1'b0;
    for (int s = 0; s < 8; s++) begin
      settle();
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", PC, exp_q[0]);
      chk("stall_insn", Instruction_if, insn_of(exp_q[0]));
      if (s == 7) begin
        chk("stall_full", 32'(q_count), 32'd4);
        chk("stall_noreq", 32'(imem_req), 32'd0);
      end
      adv();
    end
    IFWrite = 1'b1;
    settle();
    chk("perf_stalls", perf_stalls, PERF ? 32'd8 : 32'd0);
    adv();
    for (int i = 0; i < 7; i++) begin
      settle();
      chk("post_stall_valid", 32'(if_valid), 32'd1);
      adv();
    end

    // Branch to 0x42: target aligned to 0x40, in-flight word dropped
    Branch = 1'b1; BranchAddr = 32'h42;
    settle();
    chk("br_flush", 32'(IF_flush), 32'd1);
    chk("br_noreq", 32'(imem_req), 32'd0);
    adv();
    Branch = 1'b0;
    push_seq(32'h40, 16);
    settle();
    chk("br1_valid", 32'(if_valid), 32'd0);
    chk("br1_count", 32'(q_count), 32'd0);
    chk("br1_req", 32'(imem_req), 32'd1);
    chk("br1_addr", imem_addr, 32'h40);
    chk("br1_perf", perf_redirects, PERF ? 32'd1 : 32'd0);
    adv();
    settle();
    chk("br2_valid", 32'(if_valid), 32'd0);
    adv();
    settle();
    chk("br3_valid", 32'(if_valid), 32'd1);
    chk("br3_pc", PC, 32'h40);
    adv();
    for (int i = 0; i < 4; i++) step();

    // Branch and Jump together: Branch wins
    Branch = 1'b1; BranchAddr = 32'h100; Jump = 1'b1; JumpAddr = 32'h200;
    settle();
    chk("bj_flush", 32'(IF_flush), 32'd1);
    adv();
    Branch = 1'b0; Jump = 1'b0;
    push_seq(32'h100, 16);
    settle();
    chk("bj_addr", imem_addr, 32'h100);
    chk("bj_perf", perf_redirects, PERF ? 32'd2 : 32'd0);
    adv();
    for (int i = 0; i < 5; i++) step();

    // Jump to top of address space: PC wraps to 0
    Jump = 1'b1; JumpAddr = 32'hFFFF_FFFC;
    settle();
    chk("jw_flush", 32'(IF_flush), 32'd1);
    adv();
    Jump = 1'b0;
    push_seq(32'hFFFF_FFFC, 16);
    settle();
    chk("jw_addr", imem_addr, 32'hFFFF_FFFC);
    adv();
    settle();
    chk("jw_addr_wrap", imem_addr, 32'h0);
    adv();
    settle();
    chk("jw_pc", PC, 32'hFFFF_FFFC);
    adv();
    settle();
    chk("jw_pc_wrap", PC, 32'h0);
    adv();
    for (int i = 0; i < 3; i++) step();

    // Back-to-back redirects: the last one wins
    Branch = 1'b1; BranchAddr = 32'h300;
    step();
    Branch = 1'b0; Jump = 1'b1; JumpAddr = 32'h500;
    settle();
    chk("b2b_noreq", 32'(imem_req), 32'd0);
    adv();
    Jump = 1'b0;
    push_seq(32'h500, 16);
    settle();
    chk("b2b_addr", imem_addr, 32'h500);
    adv();
    for (int i = 0; i < 6; i++) step();
    settle();
    chk("perf_redir_total", perf_redirects, PERF ? 32'd5 : 32'd0);
    adv();

    // Reset mid-stream with queued words and a fetch in flight
    IFWrite = 1'b0;
    step();
    step();
    settle();
    chk("pre_rst_count", 32'(q_count), 32'd3);
    adv();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_count", 32'(q_count), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_pc", PC, 32'h0);
    chk("mid_rst_insn", Instruction_if, 32'h00000013);
    chk("mid_rst_perf", perf_stalls, 32'd0);
    IFWrite = 1'b1;
    settle();
    adv();
    reset = 1'b1;
    push_seq(32'h0, 16);
    settle();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    adv();
    settle();
    chk("rel1_valid", 32'(if_valid), 32'd0);
    adv();
    settle();
    chk("rel2_valid", 32'(if_valid), 32'd1);
    chk("rel2_pc", PC, 32'h0);
    adv();
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
